frame_fetch_ctrl: RTL

//  Sequences frame-buffer reads for the HDMI display path: at each vertical sync it flushes
//  the display line FIFO and then issues burst read requests to the DDR3 read arbiter so

---
 rtl/frame_fetch_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/frame_fetch_ctrl.sv
// Frame fetch controller: flushes the display FIFO at each frame start and
// issues credit-limited burst reads so pixel data stays ahead of de.
//
// Ports:
//   clk, rst_n         pixel clock, synchronous active-low reset
//   vs_i, de_i         display timing: vertical sync, data enable
//   fifo_empty_i       display FIFO empty flag
//   rd_req/rd_ack      read request handshake to the DDR3 arbiter
//   rd_addr, rd_len    start pixel address and pixel count of the request
//   fifo_flush         one-cycle display FIFO clear
//   underflow          sticky de-while-empty flag for the current frame
//   frame_busy         frame fetch in progress
module frame_fetch_ctrl #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   V_ACTIVE   = 720,
    parameter int   BURST_LEN  = 64,
    parameter int   FIFO_DEPTH = 2048,
    parameter int   ADDR_W     = 28,
    parameter int   FRAME_BASE = 0,
    parameter logic VS_POL     = 1'b1,
    localparam int  LEN_W      = $clog2(BURST_LEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic              fifo_empty_i,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    output logic              fifo_flush,
    output logic              underflow,
    output logic              frame_busy
);

    localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FETCH,
        WAIT_ACK,
        DONE
    } state_t;

    state_t state, next_state;

    logic              vs_q;
    logic              frame_start;
    logic              accept;
    logic              pending;
    logic              frame_done;
    logic              fits;
    logic              issue;
    logic              dec;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  remain;
    logic [LEN_W-1:0]  next_len;
    logic [CRED_W-1:0] credit;

    assign frame_start = (vs_i == VS_POL) && (vs_q != VS_POL);
    assign accept      = rd_req & rd_ack;
    assign frame_done  = (req_cnt == CNT_W'(TOTAL));
    assign remain      = CNT_W'(TOTAL) - req_cnt;

    always_comb begin
        next_len = LEN_W'(BURST_LEN);
        if (32'(remain) < 32'(BURST_LEN)) begin
            next_len = LEN_W'(remain);
        end
    end

    assign fits = (32'(credit) + 32'(next_len)) <= 32'(FIFO_DEPTH);

    // A frame start seen in FETCH wins over issuing a new request.
    assign issue = (state == FETCH) && !frame_start && !frame_done && fits;

    // A pop while credit is 0 only counts when an accept lands the same cycle.
    assign dec = de_i && ((credit != '0) || accept);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (frame_start) next_state = FLUSH;
            end
            FLUSH: begin
                next_state = FETCH;
            end
            FETCH: begin
                if (frame_start) begin
                    next_state = FLUSH;
                end else if (frame_done) begin
                    next_state = DONE;
                end else if (fits) begin
                    next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (accept) begin
                    next_state = (pending || frame_start) ? FLUSH : FETCH;
                end
            end
            DONE: begin
                if (frame_start) next_state = FLUSH;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        fifo_flush = 1'b0;
        frame_busy = 1'b0;
        unique case (state)
            FLUSH: begin
                fifo_flush = 1'b1;
                frame_busy = 1'b1;
            end
            FETCH:    frame_busy = !frame_done;
            WAIT_ACK: frame_busy = 1'b1;
            default: begin
                fifo_flush = 1'b0;
                frame_busy = 1'b0;
            end
        endcase
    end

    // Sync edge detector; resets to the active level so a sync held
    // active through reset does not look like a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q <= VS_POL;
        end else begin
            vs_q <= vs_i;
        end
    end

    // Request port: loaded on issue, held until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_req  <= 1'b0;
            rd_addr <= '0;
            rd_len  <= '0;
        end else if (issue) begin
            rd_req  <= 1'b1;
            rd_addr <= ADDR_W'(FRAME_BASE) + ADDR_W'(req_cnt);
            rd_len  <= next_len;
        end else if (accept) begin
            rd_req  <= 1'b0;
        end
    end

    // Frame counters and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt   <= '0;
            credit    <= '0;
            pending   <= 1'b0;
            underflow <= 1'b0;
        end else if (state == FLUSH) begin
            req_cnt   <= '0;
            credit    <= '0;
            pending   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (accept) begin
                req_cnt <= req_cnt + CNT_W'(rd_len);
            end
            credit <= credit
                    + (accept ? CRED_W'(rd_len) : '0)
                    - (dec ? CRED_W'(1) : '0);
            if ((state == WAIT_ACK) && frame_start && !accept) begin
                pending <= 1'b1;
            end
            if (de_i && fifo_empty_i) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
